shift_mix_columns: RTL and testbench
====================================

Name: shift_mix_columns

Overview:
- Round stage directly downstream of SubBytes in the AES datapath. Consumes the registered 128-bit SubBytes result.
- Applies ShiftRows in one cycle, then MixColumns column-serially with one column per cycle and a single shared column multiplier.
- Produces a registered 128-bit block for the following AddRoundKey stage.
- A bypass input skips MixColumns for the final AES round.

Parameters:
- RED_POLY, 8'h1B, GF(2^8) reduction constant used by xtime.

Ports:
- clock  input  1  Single clock domain; all state updates on the rising edge.
- reset  input  1  Asynchronous, active-high reset.
- start  input  1  Request to process blocoIn. Sampled on the clock edge; accepted only in IDLE.
- bypass_mix  input  1  Final-round flag, latched when start is accepted. When 1, ShiftRows only.
- blocoIn  input  [0:127]  State from SubBytes. Byte k = blocoIn[8k:8k+7]; byte k is row k%4, column k/4 (column-major).
- blocoOut  output  [0:127]  Result block, same byte mapping. Holds its value until the next completion or reset.
- busy  output  1  High while a block is in flight.
- done  output  1  One-cycle pulse; blocoOut is valid from the same cycle.

Behaviour:
- Reset (asynchronous, active-high):
  - blocoOut=0, busy=0, done=0.
  - Internal state register=0, column counter=0, FSM=IDLE.
  - An in-flight block is discarded and never reported.
- FSM states:
  - IDLE: done=0 except during the completion pulse. start=1 at edge E0 loads state <= ShiftRows(blocoIn), latches bypass_mix, clears col to 0, then:
    - goes to MIX when bypass_mix=0;
    - goes to LAST when bypass_mix=1.
  - MIX: at each edge, the column selected by col is replaced with MixColumn(column). col increments. At the edge where col=3, the full result (including column 3) is written to blocoOut, done <= 1, and the FSM returns to IDLE.
  - LAST: at the next edge, blocoOut <= state, done <= 1, FSM returns to IDLE.
- ShiftRows:
  - out byte (4c+r) = in byte (4*((c+r) mod 4) + r), for r,c in 0..3.
  - Row 0 is unchanged; rows 1/2/3 rotate left by 1/2/3 columns.
- MixColumn on column (a0,a1,a2,a3):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
  - 2x = xtime(x) = (x<<1)^(msb(x)?RED_POLY:0), where msb is bit index 0 of the [0:7] byte. 3x = xtime(x)^x.
  - All arithmetic is 8-bit XOR with no carries.
- Latency with start sampled at edge E0:
  - MixColumns: done is high in the cycle after E4. busy is high from after E0 through E4 (4 cycles).
  - Bypass: done is high after E1. busy is high for 1 cycle.
- Throughput: one block per 5 cycles with MixColumns, one per 2 cycles with bypass. start may be reasserted in the same cycle done is high, because the FSM is already in IDLE.
- start while busy=1: ignored, no queuing. blocoIn and bypass_mix changes while busy have no effect.
- done never asserts for two consecutive cycles. busy and done are never high together.
- reset asserted mid-operation: outputs clear immediately without waiting for a clock edge. After reset is released, the first start behaves as from power-on.

Decomposition:
- Shared package/include:
  - xtime function;
  - RED_POLY default;
  - FSM state encoding (IDLE, MIX, LAST);
  - byte-index helper for the [0:127] column-major mapping (shared with SubBytes and AddRoundKey).
- One sub-module: mix_column. Purely combinational, 32-bit column in and out, instantiated once. The column mux, write-back, ShiftRows wiring and FSM stay in shift_mix_columns.

Test Plan:
- Reset check: assert reset mid-MIX (after E2) -> blocoOut=0, busy=0, done=0 asynchronously; no done pulse after reset is released.
- FIPS-197 round 1: blocoIn=d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30, bypass_mix=0 -> blocoOut=04 66 81 e5 e0 cb 19 9a 48 f8 d3 7a 28 06 26 4c, done 5 cycles after start.
- ShiftRows only: blocoIn=00 01 02 ... 0f, bypass_mix=1 -> blocoOut=00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b, done 2 cycles after start.
- MixColumn vectors: columns arranged so that after ShiftRows they are db 13 53 45 / f2 0a 22 5c / 01 01 01 01 / d4 d4 d4 d5 -> 8e 4d a1 bc / 9f dc 58 9d / 01 01 01 01 / d5 d5 d7 d6.
- Handshake: pulse start again at E2 with different data -> ignored; the result is the first block. Then start in the done cycle -> second block is accepted and its done arrives 5 cycles later.
- Back-to-back: 3 blocks alternating bypass_mix 0/1/0 -> each result matches the golden model, and done pulses are exactly one cycle wide.

Source files
------------

// File: rtl/shift_mix_columns_pkg.sv
// Shared definitions for the AES ShiftRows/MixColumns round stage:
// GF(2^8) helpers, FSM encoding and the column-major byte mapping.
package shift_mix_columns_pkg;

    // Reduction constant for the AES field polynomial x^8+x^4+x^3+x+1
    localparam logic [7:0] RED_POLY_DEF = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        LAST = 2'd2
    } fsm_e;

    // Multiply by x in GF(2^8): shift left, reduce when the top bit falls out
    function automatic logic [7:0] xtime(input logic [7:0] x, input logic [7:0] poly);
        return {x[6:0], 1'b0} ^ (x[7] ? poly : 8'h00);
    endfunction

    // First bit of byte (row, col) inside a [0:127] column-major AES state
    function automatic int byte_pos(input int col, input int row);
        return 8 * (4 * col + row);
    endfunction

endpackage

// File: rtl/shift_mix_columns_mix_column.sv
// Single AES MixColumn: one 32-bit column (row 0 in the top byte) in,
// mixed column out. Purely combinational.
module mix_column
    import shift_mix_columns_pkg::*;
#(
    parameter logic [7:0] RED_POLY = RED_POLY_DEF
) (
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    assign x0 = xtime(a0, RED_POLY);
    assign x1 = xtime(a1, RED_POLY);
    assign x2 = xtime(a2, RED_POLY);
    assign x3 = xtime(a3, RED_POLY);

    // 3x is folded in as xtime(x)^x
    assign col_o[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
    assign col_o[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
    assign col_o[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
    assign col_o[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/shift_mix_columns.sv
// AES round stage after SubBytes: ShiftRows in one cycle, then MixColumns
// one column per cycle through a single shared column multiplier.
// bypass_mix skips MixColumns for the final round.
module shift_mix_columns
    import shift_mix_columns_pkg::*;
#(
    parameter logic [7:0] RED_POLY = RED_POLY_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         bypass_mix,
    input  logic [0:127] blocoIn,
    output logic [0:127] blocoOut,
    output logic         busy,
    output logic         done
);

    fsm_e         fsm_q;
    logic [1:0]   col_q;
    logic [0:127] state_q;
    logic [0:127] bloco_q;
    logic         busy_q;
    logic         done_q;

    logic [31:0]  col_in;
    logic [31:0]  col_out;
    logic [0:127] mix_state_d;

    // Pure byte permutation: rows 1/2/3 rotate left by 1/2/3 columns
    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[byte_pos(c, row) +: 8] = s[byte_pos((c + row) % 4, row) +: 8];
            end
        end
        return r;
    endfunction

    mix_column #(
        .RED_POLY (RED_POLY)
    ) u_mix_column (
        .col_i (col_in),
        .col_o (col_out)
    );

    // Select the current column and splice its mixed value back into the state
    always_comb begin
        col_in      = state_q[0:31];
        mix_state_d = state_q;
        case (col_q)
            2'd0: begin
                col_in             = state_q[0:31];
                mix_state_d[0:31]  = col_out;
            end
            2'd1: begin
                col_in             = state_q[32:63];
                mix_state_d[32:63] = col_out;
            end
            2'd2: begin
                col_in             = state_q[64:95];
                mix_state_d[64:95] = col_out;
            end
            default: begin
                col_in              = state_q[96:127];
                mix_state_d[96:127] = col_out;
            end
        endcase
    end

    // Control FSM with registered outputs; reset drops any in-flight block
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q   <= IDLE;
            col_q   <= 2'd0;
            state_q <= '0;
            bloco_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        state_q <= shift_rows(blocoIn);
                        col_q   <= 2'd0;
                        busy_q  <= 1'b1;
                        fsm_q   <= bypass_mix ? LAST : MIX;
                    end
                end
                MIX: begin
                    state_q <= mix_state_d;
                    col_q   <= col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        bloco_q <= mix_state_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        fsm_q   <= IDLE;
                    end
                end
                LAST: begin
                    bloco_q <= state_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    fsm_q   <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    fsm_q  <= IDLE;
                end
            endcase
        end
    end

    assign blocoOut = bloco_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_shift_mix_columns.sv
// Directed bench for shift_mix_columns with a result scoreboard.
module tb_shift_mix_columns;

    logic         clock;
    logic         reset;
    logic         start;
    logic         bypass_mix;
    logic [0:127] blocoIn;
    logic [0:127] blocoOut;
    logic         busy;
    logic         done;

    int passes = 0;
    int checks = 0;
    logic [0:127] sb[$];
    logic         prev_done = 1'b0;

    shift_mix_columns dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .bypass_mix (bypass_mix),
        .blocoIn    (blocoIn),
        .blocoOut   (blocoOut),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Independent GF(2^8) multiply (shift-and-add)
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [0:127] model(input logic [0:127] din, input logic byp);
        logic [7:0] ib[16];
        logic [7:0] sr[16];
        logic [7:0] ob[16];
        logic [0:127] r;
        for (int k = 0; k < 16; k++) ib[k] = din[8*k +: 8];
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                sr[4*c+row] = ib[4*((c+row)%4)+row];
        for (int c = 0; c < 4; c++) begin
            if (byp) begin
                for (int row = 0; row < 4; row++) ob[4*c+row] = sr[4*c+row];
            end else begin
                ob[4*c+0] = gmul(sr[4*c], 2) ^ gmul(sr[4*c+1], 3) ^ sr[4*c+2] ^ sr[4*c+3];
                ob[4*c+1] = sr[4*c] ^ gmul(sr[4*c+1], 2) ^ gmul(sr[4*c+2], 3) ^ sr[4*c+3];
                ob[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ gmul(sr[4*c+2], 2) ^ gmul(sr[4*c+3], 3);
                ob[4*c+3] = gmul(sr[4*c], 3) ^ sr[4*c+1] ^ sr[4*c+2] ^ gmul(sr[4*c+3], 2);
            end
        end
        for (int k = 0; k < 16; k++) r[8*k +: 8] = ob[k];
        return r;
    endfunction

    // Undo ShiftRows so a chosen post-ShiftRows state can be presented
    function automatic logic [0:127] inv_shift(input logic [0:127] t);
        logic [0:127] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[8*(4*((c+row)%4)+row) +: 8] = t[8*(4*c+row) +: 8];
        return r;
    endfunction

    // Present a block for one edge and record its expected result
    task automatic send(input logic [0:127] d, input logic byp, input logic [0:127] exp);
        @(negedge clock);
        blocoIn    = d;
        bypass_mix = byp;
        start      = 1'b1;
        sb.push_back(exp);
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done(input string tag, input int exp_edges);
        int n;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            n++;
            if (done) break;
        end
        chk(tag, n, exp_edges);
    endtask

    // Scoreboard and output invariants, sampled mid-cycle
    always @(negedge clock) begin
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) chk("unexpected_done", done, 0);
                else chk("result", blocoOut, sb.pop_front());
                chk("busy_with_done", busy, 0);
                chk("done_width", prev_done, 0);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        logic [0:127] a_blk;
        logic [0:127] b_blk;
        logic [0:127] d_blk;
        int ndone;

        reset = 1'b1; start = 1'b0; bypass_mix = 1'b0; blocoIn = '0;
        #12;
        chk("reset_blocoOut", blocoOut, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(negedge clock);
        reset = 1'b0;

        // FIPS-197 round 1
        send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0,
             128'h046681e5e0cb199a48f8d37a2806264c);
        wait_done("fips_latency", 4);

        // ShiftRows only
        send(128'h000102030405060708090a0b0c0d0e0f, 1'b1,
             128'h00050a0f04090e03080d02070c01060b);
        wait_done("bypass_latency", 1);

        // Known MixColumn vectors
        send(inv_shift(128'hdb135345f20a225c01010101d4d4d4d5), 1'b0,
             128'h8e4da1bc9fdc589d01010101d5d5d7d6);
        wait_done("mixcol_latency", 4);

        // Start during busy is ignored; then start in the done cycle
        a_blk = {$urandom, $urandom, $urandom, $urandom};
        b_blk = {$urandom, $urandom, $urandom, $urandom};
        send(a_blk, 1'b0, model(a_blk, 1'b0));
        @(posedge clock);
        @(negedge clock);
        blocoIn = b_blk; bypass_mix = 1'b1; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done("ignored_start_latency", 2);
        a_blk = {$urandom, $urandom, $urandom, $urandom};
        send(a_blk, 1'b0, model(a_blk, 1'b0));
        wait_done("restart_in_done_latency", 4);

        // Back-to-back alternating bypass
        for (int i = 0; i < 3; i++) begin
            a_blk = {$urandom, $urandom, $urandom, $urandom};
            send(a_blk, (i == 1), model(a_blk, (i == 1)));
            wait_done("b2b_latency", (i == 1) ? 1 : 4);
        end

        // Asynchronous reset mid-MIX discards the block
        d_blk = {$urandom, $urandom, $urandom, $urandom};
        send(d_blk, 1'b0, model(d_blk, 1'b0));
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("midrun_reset_blocoOut", blocoOut, 0);
        chk("midrun_reset_busy", busy, 0);
        chk("midrun_reset_done", done, 0);
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            if (done) ndone++;
        end
        chk("no_done_after_reset", ndone, 0);
        chk("idle_after_reset", busy, 0);

        // First block after reset behaves as from power-on
        d_blk = {$urandom, $urandom, $urandom, $urandom};
        send(d_blk, 1'b0, model(d_blk, 1'b0));
        wait_done("post_reset_latency", 4);

        @(posedge clock);
        @(posedge clock);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
